exec_muldiv_unit: RTL and testbench

Iterative, parametrised RV64M/RV32M multiply/divide unit attached to the execute stage. It replaces single-cycle `*`, `/` and `%` with a multi-cycle datapath that has a valid/ready handshake and flush support. The execute stage dispatches M-extension ops here and holds the pipeline on `busy`. Results return tagged with the destination register for writeback and forwarding.

---
 rtl/exec_muldiv_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_exec_muldiv_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_muldiv_unit.sv
// exec_muldiv_unit: iterative RV64M/RV32M multiply/divide for the execute stage.
// Shift-add multiply, restoring divide, sign/width fixup in a final cycle.
module exec_muldiv_unit #(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [5:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [5:0]      out_rd,
    output logic            busy
);
    localparam int CW = $clog2(XLEN + 1);
    localparam bit HAS_W = (XLEN == 64);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0] NDX = CW'(XLEN);
    localparam logic [CW-1:0] ND32 = CW'(32);
    localparam logic [CW-1:0] NMX = CW'(XLEN / MUL_BITS);
    localparam logic [CW-1:0] NM32 = CW'(32 / MUL_BITS);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*XLEN-1:0] m_q, m_d, p_q, p_d;
    logic [XLEN-1:0] b_q, b_d, r_q, r_d, res_q, res_d;
    logic [5:0] rd_q, rd_d;
    logic div_q, div_d, hi_q, hi_d, rem_q, rem_d, w_q, w_d;
    logic negq_q, negq_d, negr_q, negr_d;

    logic d_div, d_hi, d_rem, d_sa, d_sb, d_w, d_rsv;
    logic [XLEN-1:0] opa, opb, absa, absb, spec_res, dz_rem;
    logic nega, negb, dz, ovf, spec, accept;
    logic [XLEN:0] ext, diff;
    logic qbit;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo, rmd, sel;

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic s);
        logic [XLEN-1:0] r;
        r = {XLEN{s & v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    always_comb begin
        d_div = 1'b0;
        d_hi  = 1'b0;
        d_rem = 1'b0;
        d_sa  = 1'b1;
        d_sb  = 1'b1;
        d_w   = 1'b0;
        d_rsv = 1'b0;
        case (in_op)
            4'd0: ;
            4'd1: d_hi = 1'b1;
            4'd2: begin d_hi = 1'b1; d_sb = 1'b0; end
            4'd3: begin d_hi = 1'b1; d_sa = 1'b0; d_sb = 1'b0; end
            4'd4: d_div = 1'b1;
            4'd5: begin d_div = 1'b1; d_sa = 1'b0; d_sb = 1'b0; end
            4'd6: begin d_div = 1'b1; d_rem = 1'b1; end
            4'd7: begin d_div = 1'b1; d_rem = 1'b1; d_sa = 1'b0; d_sb = 1'b0; end
            4'd8: d_w = HAS_W;
            4'd9: begin d_div = 1'b1; d_w = HAS_W; end
            4'd10: begin d_div = 1'b1; d_w = HAS_W; d_sa = 1'b0; d_sb = 1'b0; end
            4'd11: begin d_div = 1'b1; d_rem = 1'b1; d_w = HAS_W; end
            4'd12: begin
                d_div = 1'b1;
                d_rem = 1'b1;
                d_w   = HAS_W;
                d_sa  = 1'b0;
                d_sb  = 1'b0;
            end
            default: d_rsv = 1'b1;
        endcase
    end

    // W ops are narrowed to 32 bits first, so the datapath only sees magnitudes
    assign opa = d_w ? ext32(in_rs1[31:0], d_sa) : in_rs1;
    assign opb = d_w ? ext32(in_rs2[31:0], d_sb) : in_rs2;
    assign nega = d_sa & opa[XLEN-1];
    assign negb = d_sb & opb[XLEN-1];
    assign absa = nega ? -opa : opa;
    assign absb = negb ? -opb : opb;

    assign dz = (opb == '0);
    assign ovf = d_sa & d_sb & (opb == '1) &
                 (d_w ? (in_rs1[31:0] == 32'h8000_0000) : (opa == MINV));
    assign spec = d_rsv | (d_div & (dz | ovf));
    assign dz_rem = d_w ? ext32(in_rs1[31:0], 1'b1) : in_rs1;

    always_comb begin
        spec_res = '0;
        if (!d_rsv) begin
            if (dz) spec_res = d_rem ? dz_rem : '1;
            else    spec_res = d_rem ? '0 : opa;
        end
    end

    assign accept = in_valid & in_ready & ~flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        p_d     = p_q;
        b_d     = b_q;
        r_d     = r_q;
        res_d   = res_q;
        rd_d    = rd_q;
        div_d   = div_q;
        hi_d    = hi_q;
        rem_d   = rem_q;
        w_d     = w_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        ext     = '0;
        diff    = '0;
        qbit    = 1'b0;
        prod    = '0;
        quo     = '0;
        rmd     = '0;
        sel     = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_d   = in_rd;
                    div_d  = d_div;
                    hi_d   = d_hi;
                    rem_d  = d_rem;
                    w_d    = d_w;
                    negq_d = nega ^ negb;
                    negr_d = nega;
                    if (spec) begin
                        res_d   = spec_res;
                        state_d = DONE;
                    end else if (d_div) begin
                        p_d = {{XLEN{1'b0}}, (d_w ? (absa << (XLEN - 32)) : absa)};
                        r_d = '0;
                        b_d = absb;
                        cnt_d = d_w ? ND32 : NDX;
                        state_d = CALC;
                    end else begin
                        m_d = {{XLEN{1'b0}}, absa};
                        p_d = '0;
                        b_d = absb;
                        cnt_d = d_w ? NM32 : NMX;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (div_q) begin
                    ext  = {r_q, p_q[XLEN-1]};
                    diff = ext - {1'b0, b_q};
                    qbit = ~diff[XLEN];
                    r_d  = qbit ? diff[XLEN-1:0] : ext[XLEN-1:0];
                    p_d  = {p_q[2*XLEN-1:XLEN], p_q[XLEN-2:0], qbit};
                end else begin
                    for (int i = 0; i < MUL_BITS; i++) begin
                        if (b_q[i]) p_d = p_d + (m_q << i);
                    end
                    m_d = m_q << MUL_BITS;
                    b_d = b_q >> MUL_BITS;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                prod = negq_q ? -p_q : p_q;
                quo  = negq_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
                rmd  = negr_q ? -r_q : r_q;
                if (div_q) sel = rem_q ? rmd : quo;
                else       sel = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
                res_d   = w_q ? ext32(sel[31:0], 1'b1) : sel;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            p_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            res_q   <= '0;
            rd_q    <= '0;
            div_q   <= 1'b0;
            hi_q    <= 1'b0;
            rem_q   <= 1'b0;
            w_q     <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            p_q     <= p_d;
            b_q     <= b_d;
            r_q     <= r_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            rem_q   <= rem_d;
            w_q     <= w_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;
    assign out_rd     = rd_q;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// tb_exec_muldiv_unit: directed and randomized checks of exec_muldiv_unit
// against an arithmetic reference model of the M-extension ops.
module tb_exec_muldiv_unit;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [63:0] in_rs1 = '0;
    logic [63:0] in_rs2 = '0;
    logic [5:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic [5:0]  out_rd;
    logic        busy;

    int n_chk = 0;
    int n_pass = 0;
    int lat;
    bit bz, seen;

    always #5 clk = ~clk;

    exec_muldiv_unit #(.XLEN(64), .MUL_BITS(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic signed [31:0] wa, wb, qw, rw;
        logic [31:0] ua, ub;
        logic signed [127:0] ps;
        logic [127:0] pu;
        bit ovf, ovw;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        ovf = (a == MIN) && (b == '1);
        ovw = (ua == 32'h8000_0000) && (ub == '1);
        q = '0; r = '0; qw = '0; rw = '0;
        if (b != 0 && !ovf) begin q = sa / sb; r = sa % sb; end
        if (ub != 0 && !ovw) begin qw = wa / wb; rw = wa % wb; end
        case (op)
            4'd0: return a * b;
            4'd1: begin
                ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                return ps[127:64];
            end
            4'd2: begin
                ps = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
                return ps[127:64];
            end
            4'd3: begin
                pu = {64'd0, a} * {64'd0, b};
                return pu[127:64];
            end
            4'd4: if (b == 0) return '1; else if (ovf) return a; else return q;
            4'd5: if (b == 0) return '1; else return a / b;
            4'd6: if (b == 0) return a; else if (ovf) return '0; else return r;
            4'd7: if (b == 0) return a; else return a % b;
            4'd8: return sx(ua * ub);
            4'd9: if (ub == 0) return '1; else if (ovw) return sx(ua); else return sx(qw);
            4'd10: if (ub == 0) return '1; else return sx(ua / ub);
            4'd11: if (ub == 0) return sx(ua); else if (ovw) return '0; else return sx(rw);
            4'd12: if (ub == 0) return sx(ua); else return sx(ua % ub);
            default: return '0;
        endcase
    endfunction

    // edges after the accepting edge until out_valid is seen
    function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
        bit w, dv, sg, z, ov;
        w  = (op >= 4'd8);
        dv = (op inside {[4'd4:4'd7], [4'd9:4'd12]});
        sg = (op inside {4'd4, 4'd6, 4'd9, 4'd11});
        z  = w ? (b[31:0] == 0) : (b == 0);
        ov = sg && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                      : (a == MIN && b == '1));
        if (op > 4'd12 || (dv && (z || ov))) return 0;
        return (w ? 32 : 64) + 1;
    endfunction

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return MIN;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'($urandom_range(0, 20));
            5: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] rd);
        @(negedge clk);
        check("in_ready before issue", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op = op;
        in_rs1 = a;
        in_rs2 = b;
        in_rd = rd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op = 4'($urandom);
        in_rs1 = {$urandom, $urandom};
        in_rs2 = {$urandom, $urandom};
        in_rd = 6'($urandom);
    endtask

    task automatic wait_done(output int l, output bit bad);
        l = 0;
        bad = 1'b0;
        @(negedge clk);
        while (!out_valid && l < 200) begin
            if (!busy) bad = 1'b1;
            @(negedge clk);
            l++;
        end
        if (!busy) bad = 1'b1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp);
        logic [5:0] rd;
        int l;
        bit bad;
        rd = 6'($urandom);
        issue(op, a, b, rd);
        wait_done(l, bad);
        check($sformatf("result op%0d a=%h b=%h", op, a, b), out_result, exp);
        check($sformatf("out_rd op%0d", op), 64'(out_rd), 64'(rd));
        check($sformatf("latency op%0d", op), 64'(l), 64'(ref_lat(op, a, b)));
        check($sformatf("busy op%0d", op), 64'(bad), 64'd0);
    endtask

    initial begin
        logic [3:0] op;
        logic [63:0] a, b;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst out_result", out_result, 64'd0);
        check("rst out_rd", 64'(out_rd), 64'd0);
        reset = 1'b0;

        run_op(4'd0, 64'd7, -64'd3, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(4'd4, -64'd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd6, -64'd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(4'd9, 64'h0000_0000_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd5, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(4'd6, 64'd5, 64'd0, 64'd5);
        run_op(4'd4, MIN, '1, MIN);
        run_op(4'd6, MIN, '1, 64'd0);
        run_op(4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(4'd8, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(4'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(4'd4, 64'd20, -64'd6, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd6, 64'd20, -64'd6, 64'd2);
        run_op(4'd13, 64'd9, 64'd9, 64'd0);

        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 15));
            a = rnd_val();
            b = rnd_val();
            run_op(op, a, b, ref_res(op, a, b));
        end

        // flush in the middle of CALC
        issue(4'd0, 64'd123, 64'd456, 6'd9);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush in_ready", 64'(in_ready), 64'd1);
        check("flush busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush no out_valid", 64'(seen), 64'd0);
        run_op(4'd0, 64'd123, 64'd456, 64'd56088);

        // flush together with in_valid blocks acceptance
        @(negedge clk);
        in_valid = 1'b1;
        flush = 1'b1;
        in_op = 4'd0;
        in_rs1 = 64'd3;
        in_rs2 = 64'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush+valid busy", 64'(busy), 64'd0);
        check("flush+valid in_ready", 64'(in_ready), 64'd1);

        // result held while out_ready is low
        out_ready = 1'b0;
        issue(4'd5, 64'd100, 64'd7, 6'd33);
        wait_done(lat, bz);
        check("hold latency", 64'(lat), 64'd65);
        repeat (5) begin
            check("hold result", out_result, 64'd14);
            check("hold rd", 64'(out_rd), 64'd33);
            check("hold in_ready", 64'(in_ready), 64'd0);
            check("hold out_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release out_valid", 64'(out_valid), 64'd0);
        check("release in_ready", 64'(in_ready), 64'd1);

        // flush discards a waiting result
        out_ready = 1'b0;
        issue(4'd5, 64'd5, 64'd0, 6'd7);
        @(negedge clk);
        check("done before flush", 64'(out_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush done out_valid", 64'(out_valid), 64'd0);
        check("flush done in_ready", 64'(in_ready), 64'd1);

        // asynchronous reset mid-CALC
        issue(4'd4, -64'd1000, 64'd7, 6'd17);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid rst in_ready", 64'(in_ready), 64'd1);
        check("mid rst out_valid", 64'(out_valid), 64'd0);
        check("mid rst busy", 64'(busy), 64'd0);
        check("mid rst out_result", out_result, 64'd0);
        check("mid rst out_rd", 64'(out_rd), 64'd0);
        #1 reset = 1'b0;
        run_op(4'd4, -64'd1000, 64'd7, -64'd142);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
